// File: rtl/uart_recv.sv
// rtl/uart_recv.sv - UART receiver: 8 data bits, even parity, 1 stop, CPU read handshake
// Line is sampled mid-bit from a 2-flop synchronised copy; status flags travel with the byte.
module uart_recv #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        RxD,
    input  logic        RD,
    output logic [31:0] Dout,
    output logic        RxRDY,
    output logic        PErr,
    output logic        FErr,
    output logic        OErr
);

    localparam int H     = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(H - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic             r_sync1;
    logic             r_sync2;
    logic             r_rxs_prev;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_parity;
    logic             r_perr_pend;

    logic [7:0]       r_dout;
    logic             r_rxrdy;
    logic             r_perr;
    logic             r_ferr;
    logic             r_oerr;

    logic             w_rxs;
    logic             w_fall;
    logic             w_cnt_clr;
    logic             w_shift_en;
    logic             w_par_en;
    logic             w_complete;

    assign w_rxs  = r_sync2;
    // Edge-triggered start: a line stuck low after a framing error never restarts
    assign w_fall = r_rxs_prev & ~w_rxs;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_cnt_clr    = 1'b0;
        w_shift_en   = 1'b0;
        w_par_en     = 1'b0;
        w_complete   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fall) begin
                    w_next_state = S_START;
                    w_cnt_clr    = 1'b1;
                end
            end
            S_START: begin
                if (r_cnt == CNT_HALF) begin
                    w_cnt_clr    = 1'b1;
                    w_next_state = w_rxs ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_cnt == CNT_FULL) begin
                    w_cnt_clr  = 1'b1;
                    w_shift_en = 1'b1;
                    if (r_bit_idx == 3'd7) begin
                        w_next_state = S_PARITY;
                    end
                end
            end
            S_PARITY: begin
                if (r_cnt == CNT_FULL) begin
                    w_cnt_clr    = 1'b1;
                    w_par_en     = 1'b1;
                    w_next_state = S_STOP;
                end
            end
            S_STOP: begin
                if (r_cnt == CNT_FULL) begin
                    w_cnt_clr    = 1'b1;
                    w_complete   = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_rxs_prev  <= 1'b1;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_parity    <= 1'b0;
            r_perr_pend <= 1'b0;
        end else begin
            r_sync1    <= RxD;
            r_sync2    <= r_sync1;
            r_rxs_prev <= w_rxs;

            if (w_cnt_clr || r_state == S_IDLE) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (r_state == S_START) begin
                r_bit_idx <= '0;
                r_parity  <= 1'b0;
            end else if (w_shift_en) begin
                r_shift   <= {w_rxs, r_shift[7:1]};
                r_parity  <= r_parity ^ w_rxs;
                r_bit_idx <= r_bit_idx + 3'd1;
            end

            if (w_par_en) begin
                r_perr_pend <= r_parity ^ w_rxs;
            end
        end
    end

    // A completing frame is accepted when the holding register is empty or being read now
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_dout  <= '0;
            r_rxrdy <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_oerr  <= 1'b0;
        end else if (w_complete) begin
            if (!r_rxrdy || RD) begin
                r_dout  <= r_shift;
                r_perr  <= r_perr_pend;
                r_ferr  <= ~w_rxs;
                r_rxrdy <= 1'b1;
                r_oerr  <= r_oerr & ~RD;
            end else begin
                r_oerr  <= 1'b1;
            end
        end else if (RD && r_rxrdy) begin
            r_rxrdy <= 1'b0;
            r_oerr  <= 1'b0;
        end
    end

    assign Dout  = {24'b0, r_dout};
    assign RxRDY = r_rxrdy;
    assign PErr  = r_perr;
    assign FErr  = r_ferr;
    assign OErr  = r_oerr;

endmodule

// File: tb/tb_uart_recv.sv
// tb/tb_uart_recv.sv - directed scoreboard bench for uart_recv
module tb_uart_recv;

    localparam int CPB = 16;
    localparam int LAT = 2 + CPB / 2 + 10 * CPB;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        RxD   = 1'b1;
    logic        RD    = 1'b0;
    logic [31:0] Dout;
    logic        RxRDY;
    logic        PErr;
    logic        FErr;
    logic        OErr;

    int vectors     = 0;
    int miscompares = 0;

    // {byte, perr, ferr}
    logic [9:0] sb_q[$];

    always #5 Clock = ~Clock;

    uart_recv #(.CLKS_PER_BIT(CPB)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .RxD   (RxD),
        .RD    (RD),
        .Dout  (Dout),
        .RxRDY (RxRDY),
        .PErr  (PErr),
        .FErr  (FErr),
        .OErr  (OErr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge Clock);
    endtask

    task automatic pulse_rd();
        @(negedge Clock);
        RD = 1'b1;
        @(negedge Clock);
        RD = 1'b0;
    endtask

    task automatic push(input logic [7:0] b, input logic perr, input logic ferr);
        sb_q.push_back({b, perr, ferr});
    endtask

    // Bit k occupies negedges 16k..16k+15; negedge c lies after posedge c
    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop,
                              input int rd_at, input int abort_at, input bit lat);
        logic [10:0] frame;
        frame = {stop, par, b, 1'b0};
        for (int c = 0; c < 11 * CPB; c++) begin
            @(negedge Clock);
            if (c == abort_at) begin
                Reset = 1'b0;
                RD    = 1'b0;
                return;
            end
            if (lat && c == LAT)     chk1("latency_before", RxRDY, 1'b0);
            if (lat && c == LAT + 1) chk1("latency_after", RxRDY, 1'b1);
            RxD = frame[c / CPB];
            RD  = (c == rd_at);
        end
        @(negedge Clock);
        RD = 1'b0;
    endtask

    task automatic wait_pop(input string tag);
        logic [9:0] e;
        int n;
        n = 0;
        while (RxRDY !== 1'b1 && n < 400) begin
            @(negedge Clock);
            n++;
        end
        chk1({tag, "_rdy"}, RxRDY, 1'b1);
        if (sb_q.size() == 0) begin
            chk({tag, "_sb"}, 32'(sb_q.size()), 32'd1);
            return;
        end
        e = sb_q.pop_front();
        chk ({tag, "_dout"}, Dout, {24'b0, e[9:2]});
        chk1({tag, "_perr"}, PErr, e[1]);
        chk1({tag, "_ferr"}, FErr, e[0]);
    endtask

    initial begin
        idle(3);
        chk ("reset_dout", Dout, 32'h0);
        chk1("reset_rdy", RxRDY, 1'b0);
        chk1("reset_perr", PErr, 1'b0);
        chk1("reset_ferr", FErr, 1'b0);
        chk1("reset_oerr", OErr, 1'b0);
        Reset = 1'b1;
        idle(5);

        // Clean byte with latency check, then read
        push(8'hA5, 1'b0, 1'b0);
        send_frame(8'hA5, ^8'hA5, 1'b1, -1, -1, 1'b1);
        wait_pop("a5");
        pulse_rd();
        @(negedge Clock);
        chk1("a5_rd_rdy", RxRDY, 1'b0);
        chk ("a5_rd_dout", Dout, 32'h0000_00A5);

        // Parity error, then a good byte with the read landing mid-frame
        idle(5);
        push(8'h3C, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b1, -1, -1, 1'b0);
        wait_pop("3c");
        idle(5);
        push(8'h01, 1'b0, 1'b0);
        send_frame(8'h01, 1'b1, 1'b1, 50, -1, 1'b0);
        wait_pop("01");
        chk1("01_oerr", OErr, 1'b0);
        pulse_rd();

        // Framing error with the line held low: no restart until it rises and falls
        idle(5);
        push(8'hFF, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b0, -1, -1, 1'b0);
        wait_pop("ff");
        pulse_rd();
        idle(200);
        chk1("ff_low_rdy", RxRDY, 1'b0);
        RxD = 1'b1;
        idle(10);
        push(8'h00, 1'b0, 1'b0);
        send_frame(8'h00, 1'b0, 1'b1, -1, -1, 1'b0);
        wait_pop("00");
        pulse_rd();

        // Short glitch is a false start
        idle(5);
        RxD = 1'b0;
        idle(4);
        RxD = 1'b1;
        idle(30);
        chk1("glitch_rdy", RxRDY, 1'b0);
        push(8'h55, 1'b0, 1'b0);
        send_frame(8'h55, 1'b0, 1'b1, -1, -1, 1'b0);
        wait_pop("55");
        pulse_rd();

        // Overrun, clear, then reads coinciding with the completion edge
        idle(5);
        push(8'h11, 1'b0, 1'b0);
        send_frame(8'h11, 1'b0, 1'b1, -1, -1, 1'b0);
        wait_pop("11");
        idle(5);
        send_frame(8'h22, 1'b0, 1'b1, -1, -1, 1'b0);
        chk ("ovr_dout", Dout, 32'h0000_0011);
        chk1("ovr_oerr", OErr, 1'b1);
        chk1("ovr_rdy", RxRDY, 1'b1);
        pulse_rd();
        @(negedge Clock);
        chk1("ovr_rd_rdy", RxRDY, 1'b0);
        chk1("ovr_rd_oerr", OErr, 1'b0);
        idle(5);
        push(8'h33, 1'b0, 1'b0);
        send_frame(8'h33, 1'b0, 1'b1, LAT, -1, 1'b0);
        wait_pop("33");
        chk1("33_oerr", OErr, 1'b0);
        idle(5);
        push(8'h44, 1'b0, 1'b0);
        send_frame(8'h44, 1'b0, 1'b1, LAT, -1, 1'b0);
        wait_pop("44");
        chk1("44_oerr", OErr, 1'b0);

        // Asynchronous reset mid-data aborts the frame
        idle(5);
        send_frame(8'h5A, 1'b0, 1'b1, -1, 5 * CPB, 1'b0);
        #1;
        chk ("rst_dout", Dout, 32'h0);
        chk1("rst_rdy", RxRDY, 1'b0);
        chk1("rst_perr", PErr, 1'b0);
        chk1("rst_ferr", FErr, 1'b0);
        chk1("rst_oerr", OErr, 1'b0);
        RxD = 1'b1;
        idle(5);
        Reset = 1'b1;
        idle(5);
        push(8'h5A, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b1, -1, -1, 1'b0);
        wait_pop("5a");
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
